// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one registered DATA_W-bit adder between NUM_REQ
// valid/ready requesters and returns each sum, tagged with its requester id, on one response channel.
module adder_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W:0]           rsp_sum,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum_reg;

    // Index arithmetic modulo NUM_REQ, which need not be a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offset);
        int total;
        total = int'(base) + offset;
        if (total >= NUM_REQ) total = total - NUM_REQ;
        return ID_W'(total);
    endfunction

    // Search starts at rr_ptr so the last-served requester drops to lowest priority.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[wrap_add(rr_ptr, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_ptr, i);
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = CALC;
                end
            end
            CALC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            op_a     <= '0;
            op_b     <= '0;
            sum_reg  <= '0;
        end else begin
            if (state == IDLE && grant_found) begin
                op_a     <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
                op_b     <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
                grant_id <= grant_idx;
            end
            if (state == CALC) sum_reg <= {1'b0, op_a} + {1'b0, op_b};
            // Pointer advances only on acceptance, never on grant.
            if (state == RESP && rsp_ready) rr_ptr <= wrap_add(grant_id, 1);
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_id    = grant_id;
    assign rsp_sum   = sum_reg;

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one registered 8-bit adder (9-bit sum, 1-cycle compute) between NUM_REQ requesters.
- Arbitration is round-robin. Each request is a valid/ready operand pair.
- Each result returns on one response channel, tagged with the requester index, and is held until the consumer accepts it.
- Sits between the requester agents and the shared adder datapath. It contains its own instance of the adder function (registered add, clear on reset).

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, operand width; sum width is DATA_W+1
- ID_W, 2, width of requester index; must be at least clog2(NUM_REQ)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high
- req_a  input  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
- req_b  input  NUM_REQ*DATA_W  operand B, same packing
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_W  index of requester that owns rsp_sum
- rsp_sum  output  DATA_W+1  unsigned sum a+b, carry in MSB
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: clk-synchronous, active-high; dominates all other inputs.
  - Forces state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0, req_ready=0.
  - Operand/grant registers cleared.
  - An in-flight operation is discarded; no response is produced for it.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid, grant g = first index with req_valid high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle only, so the handshake completes this cycle.
  - Latch req_a[g], req_b[g] and g at the clock edge, then go to CALC.
  - If no req_valid, all req_ready=0 and the FSM stays in IDLE.
- CALC:
  - Registered add: sum_reg <= {1'b0,op_a} + {1'b0,op_b}, computed at full DATA_W+1 width with no truncation.
  - Next state: RESP.
  - All req_ready=0.
- RESP:
  - rsp_valid=1. rsp_sum and rsp_id are stable and unchanged until accepted.
  - On rsp_valid && rsp_ready: rr_ptr <= (g+1) mod NUM_REQ, go to IDLE, rsp_valid=0 from the next cycle.
  - If rsp_ready is low, stay in RESP indefinitely (backpressure). All req_ready=0.
- Latency: request handshake edge to rsp_valid is 2 cycles. Minimum spacing between accepted requests is 3 cycles (IDLE, CALC, RESP).
- rsp_ready while rsp_valid=0 is ignored.
- req_valid may drop at any time before its handshake; a non-granted requester is never charged.
- Fairness: a requester held continuously valid is granted within NUM_REQ grants.
- The pointer moves only on response acceptance, never on grant alone.
- Simultaneous requests from all requesters are granted in index order starting at rr_ptr.
- Operands are sampled only on the handshake cycle. Changes to req_a/req_b afterwards do not affect the result.
- busy = (state != IDLE).

Test Plan:
- Reset then single request: req 1 valid, a=8'd100, b=8'd27.
  - Expect req_ready[1]=1 that cycle.
  - Expect rsp_valid 2 cycles later with rsp_id=1, rsp_sum=9'd127.
  - Expect rr_ptr=2 after acceptance.
- Carry: a=8'hFF, b=8'hFF on req 0.
  - Expect rsp_sum=9'h1FE.
  - a=8'h80, b=8'h80: expect 9'h100.
- Round-robin: all 4 requesters valid continuously with rsp_ready tied high.
  - Grant order is 0,1,2,3,0.
  - Each response tagged with the matching id.
  - Responses are 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while req 2 is valid.
  - rsp_sum/rsp_id remain stable.
  - req_ready stays all-zero.
  - req 2 is granted only after the accept cycle, in the following IDLE cycle.
- Operand change after grant: change req_a right after the handshake.
  - Response reflects the originally sampled values.
- Reset mid-operation: assert reset in CALC and, separately, in RESP.
  - Next cycle: rsp_valid=0, busy=0, rsp_sum=0, rr_ptr=0.
  - No stale response appears afterwards.
  - First post-reset grant goes to the lowest valid index.
